// File: rtl/elastic_stage_reg_pkg.sv
// Shared constants for the elastic pipeline stage register.
//   MAX_DEPTH       largest legal number of slots
//   DEF_BIT_NUMBER  default width of one channel
//   DEF_CHANNELS    default number of packed channels
//   CH_PC/CH_INSTR  default channel indices (program counter, instruction word)
//   channel_lsb()   lowest bit of channel `ch` inside a packed word
package elastic_stage_reg_pkg;

    localparam int MAX_DEPTH      = 4;
    localparam int DEF_BIT_NUMBER = 32;
    localparam int DEF_CHANNELS   = 2;
    localparam int CH_PC          = 0;
    localparam int CH_INSTR       = 1;

    function automatic int channel_lsb(input int ch, input int bit_number);
        return ch * bit_number;
    endfunction

endpackage

// File: rtl/elastic_slot.sv
// One storage slot of the elastic stage: a valid bit and a data word.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset (clears valid and data)
//   clear      synchronous squash: valid and data go to 0 at the next edge
//   load       slot is allowed to advance this cycle
//   src_valid  the upstream neighbour offers a word
//   src_data   that word
//   valid      registered valid bit
//   data       registered data word
// A loading slot takes src_valid as its new valid bit; data is only
// overwritten when a word actually arrives, so an emptied slot keeps its
// stale data.
module elastic_slot
    import elastic_stage_reg_pkg::*;
#(
    parameter int WIDTH = DEF_CHANNELS * DEF_BIT_NUMBER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d,  data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (clear) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else if (load) begin
            valid_d = src_valid;
            if (src_valid) begin
                data_d = src_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: rtl/elastic_stage_reg.sv
// Parametrised pipeline stage register (e.g. EXE->MEM, MEM->WB).
// Carries CHANNELS packed fields of BIT_NUMBER bits through DEPTH slots.
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   freeze     stall: every slot holds, no handshake completes
//   flush      squash: every slot is cleared at the next edge
//   in_valid   / in_ready  / in_data   upstream handshake and word
//   out_valid  / out_ready / out_data  downstream handshake and word (last slot)
//   occupancy  number of valid slots (from registered valid bits)
//
// Handshake: a word moves across a port on a rising edge where valid and
// ready are both 1 at that port. valid never depends on ready of the same
// port; in_ready depends on out_ready combinationally (bubble collapse),
// which for DEPTH=1 is a direct out_ready->in_ready path. Both in_ready and
// out_valid are forced low during freeze and flush, so no transfer completes
// while the stage is stalled or being squashed.
module elastic_stage_reg
    import elastic_stage_reg_pkg::*;
#(
    parameter int BIT_NUMBER = DEF_BIT_NUMBER,
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int DEPTH      = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           freeze,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHANNELS*BIT_NUMBER-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CHANNELS*BIT_NUMBER-1:0] out_data,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy
);

    localparam int W     = CHANNELS * BIT_NUMBER;
    localparam int OCC_W = $clog2(DEPTH + 1);

    if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_bad_depth
        $fatal(1, "elastic_stage_reg: DEPTH must be in 1..%0d", MAX_DEPTH);
    end

    logic [DEPTH-1:0] slot_valid;
    logic [DEPTH-1:0] slot_rdy;
    logic [DEPTH-1:0] slot_load;
    logic [DEPTH-1:0] slot_src_valid;
    logic [W-1:0]     slot_data     [DEPTH];
    logic [W-1:0]     slot_src_data [DEPTH];
    logic             in_fire;

    // A slot can take a word if it is empty or if the slot after it can
    // move on this cycle; this lets words close up gaps (bubble collapse).
    always_comb begin
        slot_rdy = '0;
        slot_rdy[DEPTH-1] = !slot_valid[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            slot_rdy[i] = !slot_valid[i] | slot_rdy[i+1];
        end
    end

    // in_ready is also held low during reset so nothing looks accepted
    // while the slots are being cleared.
    always_comb begin
        in_ready  = slot_rdy[0] & !freeze & !flush & rst;
        out_valid = slot_valid[DEPTH-1] & !freeze & !flush;
        out_data  = slot_data[DEPTH-1];
        in_fire   = in_valid & in_ready;
    end

    // Slot 0 is fed from the input port, every later slot from its
    // predecessor. Freeze blocks all loads; flush is handled by clear,
    // which wins over load inside the slot.
    always_comb begin
        slot_src_valid    = '0;
        slot_src_valid[0] = in_fire;
        slot_src_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            slot_src_valid[i] = slot_valid[i-1];
            slot_src_data[i]  = slot_data[i-1];
        end
        slot_load = slot_rdy & {DEPTH{!freeze}};
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        elastic_slot #(
            .WIDTH (W)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .clear     (flush),
            .load      (slot_load[g]),
            .src_valid (slot_src_valid[g]),
            .src_data  (slot_src_data[g]),
            .valid     (slot_valid[g]),
            .data      (slot_data[g])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(slot_valid[i]);
        end
    end

endmodule
